// File: rtl/uart_rx_8bit.sv
// rtl/uart_rx_8bit.sv - UART byte receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_8bit #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Receive FSM: mid-bit sampling, byte assembly and registered result/error pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            // A start bit that is gone by mid-bit was only a glitch
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= ^{shift, rx_s};
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              // Framing error wins over parity; wait for the line to recover
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data_out   <= shift;
                data_valid <= 1'b1;
              end
`else
              data_out   <= shift;
              data_valid <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          // A line held low must return high before a new start is accepted
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8bit.sv
// tb/tb_uart_rx_8bit.sv - self-checking bench for uart_rx_8bit
module tb_uart_rx_8bit;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_EXP = 2 + CPB / 2 + 10 * CPB;
  localparam int FRAME   = 11 * CPB;
`else
  localparam int LAT_EXP = 2 + CPB / 2 + 9 * CPB;
  localparam int FRAME   = 10 * CPB;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx_8bit #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: records every output event observed on the falling edge
  logic [7:0] got_q[$];
  int         dv_cyc_q[$];
  logic       dv_busy_q[$];
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         clash_cnt = 0;
  always @(negedge CLK) begin
    if (data_valid) begin
      got_q.push_back(data_out);
      dv_cyc_q.push_back(cyc);
      dv_busy_q.push_back(busy);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (data_valid && (frame_err || parity_err)) clash_cnt <= clash_cnt + 1;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         rd_idx = 0;
  logic [7:0] exp_data = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_bit);
  endtask

  // Compares every byte the monitor captured since the last call with the expected queue
  task automatic scoreboard_check(input string tag);
    logic [7:0] e;
    check({tag, "_count"}, got_q.size(), rd_idx + exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        check({tag, "_byte"}, got_q[rd_idx], e);
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
  endtask

  initial begin
    int base;
    int fall0;
    int fall1;
    int fe0;

    // Reset and idle
    cycles(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    RST = 1'b0;
    cycles(500);
    check("idle_data_out", data_out, 8'h00);
    check("idle_busy", busy, 1'b0);
    scoreboard_check("idle");

    // Single good frame
    base  = got_q.size();
    fall0 = cyc;
    exp_q.push_back(8'hA5);
    exp_data = 8'hA5;
    send_frame(8'hA5, 1'b1);
    cycles(20);
    scoreboard_check("a5");
    check("a5_data_out", data_out, exp_data);
    if (got_q.size() > base) begin
      check_range("a5_latency", dv_cyc_q[base] - fall0, LAT_EXP - 1, LAT_EXP + 2);
      check("a5_busy_at_dv", dv_busy_q[base], 1'b0);
    end
    check("a5_busy_after", busy, 1'b0);

    // Back-to-back frames, no idle gap
    base  = got_q.size();
    fall0 = cyc;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    fall1 = cyc;
    exp_q.push_back(8'hFF);
    exp_data = 8'hFF;
    send_frame(8'hFF, 1'b1);
    cycles(20);
    scoreboard_check("b2b");
    check("b2b_data_out", data_out, exp_data);
    check("b2b_gap", fall1 - fall0, FRAME);
    if (got_q.size() >= base + 2)
      check_range("b2b_dv_spacing", dv_cyc_q[base + 1] - dv_cyc_q[base], FRAME - 1, FRAME + 1);

    // Short glitch is rejected
    fe0 = fe_cnt;
    rx_in = 1'b0;
    cycles(4);
    rx_in = 1'b1;
    cycles(30);
    check("glitch_busy", busy, 1'b0);
    check("glitch_frame_err", fe_cnt, fe0);
    scoreboard_check("glitch");

    // Framing error followed by a held-low line
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    cycles(400);
    check("ferr_count", fe_cnt, fe0 + 1);
    check("break_busy", busy, 1'b1);
    check("ferr_data_out", data_out, exp_data);
    scoreboard_check("ferr");
    rx_in = 1'b1;
    cycles(20);
    check("break_exit_busy", busy, 1'b0);
    check("break_no_more_err", fe_cnt, fe0 + 1);

    // Reset in the middle of 0x81, then a clean 0x42
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b1 : 1'b0);
    rx_in = 1'b0;
    cycles(CPB / 2);
    RST = 1'b1;
    cycles(2);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data_out", data_out, 8'h00);
    exp_data = 8'h00;
    rx_in = 1'b1;
    cycles(2);
    RST = 1'b0;
    cycles(200);
    scoreboard_check("midrst_81");
    exp_q.push_back(8'h42);
    exp_data = 8'h42;
    send_frame(8'h42, 1'b1);
    cycles(20);
    scoreboard_check("after_rst_42");
    check("after_rst_data_out", data_out, exp_data);
    check("midrst_frame_err", fe_cnt, fe0);

`ifdef UART_RX_PARITY_EN
    // Parity accepted, then parity mismatch
    exp_q.push_back(8'h07);
    exp_data = 8'h07;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    cycles(20);
    scoreboard_check("par_ok");
    check("par_ok_data_out", data_out, exp_data);
    check("par_ok_no_perr", pe_cnt, 0);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    cycles(20);
    par_flip = 1'b0;
    scoreboard_check("par_bad");
    check("par_bad_perr", pe_cnt, 1);
    check("par_bad_data_out", data_out, exp_data);
`else
    check("no_parity_err", pe_cnt, 0);
`endif

    check("err_with_valid", clash_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
